// File: rtl/inv_ark_sequencer.sv
// Inverse AddRoundKey sequencer: XORs each incoming state beat with the
// round key for the current round, walking rounds 10 down to 0 per block.
module inv_ark_sequencer (
  input  logic             clk,
  input  logic             rst,
  input  logic             rk_we,
  input  logic [3:0]       rk_addr,
  input  logic [3:0][31:0] rk_i,
  output logic             key_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0][31:0] state_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0][31:0] state_o,
  output logic [3:0]       round_o,
  output logic             last_o
);

  typedef enum logic {IDLE, ACTIVE} fsm_t;

  localparam logic [3:0] LAST_RND = 4'd10;

  fsm_t             fsm_q, fsm_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [3:0][31:0] st_q, st_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             kerr_q, kerr_d;
  logic [3:0][31:0] key_q [11];
  logic [3:0][31:0] key_sel;
  logic             accept;
  logic             idle;
  logic             key_ok;

  assign in_ready  = !vld_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign idle      = (fsm_q == IDLE) && (cnt_q == LAST_RND) && !vld_q;
  // A write racing the round-10 acceptance would change the key the
  // block is about to start with, so it is refused.
  assign key_ok    = rk_we && (rk_addr <= LAST_RND) && idle && !accept;
  assign key_sel   = (cnt_q <= LAST_RND) ? key_q[cnt_q] : '0;

  assign out_valid = vld_q;
  assign state_o   = st_q;
  assign round_o   = rnd_q;
  assign last_o    = vld_q && (rnd_q == 4'd0);
  assign key_err   = kerr_q;

  // Next state for round FSM, counter and output register
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    st_d   = st_q;
    rnd_d  = rnd_q;
    kerr_d = rk_we && !key_ok;
    if (accept) begin
      st_d  = state_i ^ key_sel;
      rnd_d = cnt_q;
      vld_d = 1'b1;
      if (cnt_q == 4'd0) begin
        cnt_d = LAST_RND;
        fsm_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
        fsm_d = ACTIVE;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= LAST_RND;
      vld_q  <= 1'b0;
      st_q   <= '0;
      rnd_q  <= 4'd0;
      kerr_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      kerr_q <= kerr_d;
    end
  end

  // Round-key storage, writable only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) key_q[i] <= '0;
    end else if (key_ok) begin
      key_q[rk_addr] <= rk_i;
    end
  end

endmodule

// File: tb/tb_inv_ark_sequencer.sv
// Scoreboard bench for inv_ark_sequencer: driver pushes expected beats,
// a negedge monitor pops and compares on each output handshake.
module tb_inv_ark_sequencer;

  typedef logic [3:0][31:0] blk_t;
  typedef struct {
    blk_t       s;
    logic [3:0] r;
    logic       l;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rk_we;
  logic [3:0] rk_addr;
  blk_t       rk_i;
  logic       key_err;
  logic       in_valid;
  logic       in_ready;
  blk_t       state_i;
  logic       out_valid;
  logic       out_ready;
  blk_t       state_o;
  logic [3:0] round_o;
  logic       last_o;

  exp_t sb[$];
  blk_t tkey [11];
  int   tcnt;
  int   checks;
  int   failures;

  inv_ark_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .rk_we     (rk_we),
    .rk_addr   (rk_addr),
    .rk_i      (rk_i),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_i   (state_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_o   (state_o),
    .round_o   (round_o),
    .last_o    (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL mon_extra act=round%0d exp=none", round_o);
      end else begin
        e = sb.pop_front();
        if (state_o !== e.s || round_o !== e.r || last_o !== e.l) begin
          failures++;
          $display("FAIL mon_beat act=%h/r%0d/l%0b exp=%h/r%0d/l%0b",
                   state_o, round_o, last_o, e.s, e.r, e.l);
        end
      end
    end
  end

  // Offer one beat; push expected (hand value if hand=1) on acceptance
  task automatic send(input blk_t s, input bit hand, input blk_t he,
                      output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    state_i = s;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      tries++;
      @(posedge clk);
    end
    if (acc) begin
      sb.push_back('{hand ? he : (s ^ tkey[tcnt]), tcnt[3:0], tcnt == 0});
      tcnt = (tcnt == 0) ? 10 : tcnt - 1;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout act=no_accept exp=accept");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic kwrite(input logic [3:0] a, input blk_t d, input bit err);
    rk_we = 1'b1;
    rk_addr = a;
    rk_i = d;
    @(posedge clk);
    #1;
    rk_we = 1'b0;
    if (!err) tkey[a] = d;
    @(negedge clk);
    chk("key_err", key_err, err);
    @(posedge clk);
    #1;
    chk("key_err_clr", key_err, 0);
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic blk_t mkv(input int i);
    blk_t v;
    v[0] = 32'h1111_1111 * i;
    v[1] = 32'hA5A5_0000 ^ i;
    v[2] = 32'h0F0F_F0F0 + i;
    v[3] = {i[7:0], 24'h00C0DE};
    return v;
  endfunction

  localparam blk_t K10  = {32'h01234567, 32'h01234567,
                           32'h89ABCDEF, 32'h89ABCDEF};
  localparam blk_t K9   = {32'h89ABCDEF, 32'h456789AB,
                           32'h0123CDEF, 32'h456789AB};
  localparam blk_t K0   = {32'hDEADBEEF, 32'hCAFEF00D,
                           32'h12345678, 32'h9ABCDEF0};
  localparam blk_t E9   = {32'h88888888, 32'h4444CCCC,
                           32'h88880000, 32'hCCCC4444};
  localparam blk_t KNEW = {32'hFFFF0000, 32'h0000FFFF,
                           32'h5555AAAA, 32'hAAAA5555};

  initial begin
    int tr;
    checks = 0;
    failures = 0;
    tcnt = 10;
    for (int i = 0; i < 11; i++) tkey[i] = '0;
    rst = 1'b1;
    rk_we = 1'b0;
    rk_addr = 4'd0;
    rk_i = '0;
    in_valid = 1'b0;
    state_i = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_state", state_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_kerr", key_err, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    kwrite(4'd10, K10, 1'b0);
    kwrite(4'd9, K9, 1'b0);
    kwrite(4'd0, K0, 1'b0);

    // Block 1: hand-computed rounds 10 and 9, stall, then stream 8..0
    out_ready = 1'b1;
    send(K10, 1'b1, '0, tr);
    send(K10, 1'b1, E9, tr);
    out_ready = 1'b0;
    fork
      send(mkv(8), 1'b0, '0, tr);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", in_ready, 0);
          chk("stall_valid", out_valid, 1);
          chk("stall_round", round_o, 9);
          chk("stall_state", state_o, E9);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 7; i >= 0; i--) begin
      send(mkv(i), 1'b0, '0, tr);
      chk("thru", tr, 1);
    end
    drain();

    // Block 2: rejected writes (bad address, racing round-10 accept)
    kwrite(4'd11, KNEW, 1'b1);
    rk_we = 1'b1;
    rk_addr = 4'd10;
    rk_i = KNEW;
    in_valid = 1'b1;
    state_i = mkv(20);
    @(negedge clk);
    chk("race_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back('{mkv(20) ^ tkey[10], 4'd10, 1'b0});
    tcnt = 9;
    #1;
    rk_we = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("race_kerr", key_err, 1);
    @(posedge clk);
    #1;
    for (int i = 9; i >= 0; i--) send(mkv(30 + i), 1'b0, '0, tr);
    drain();

    // Block 3: key[10] must still be K10, then reset mid-block
    send(K10, 1'b1, '0, tr);
    for (int i = 9; i >= 5; i--) send(mkv(40 + i), 1'b0, '0, tr);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_round", round_o, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_round", round_o, 0);
    chk("mid_rst_last", last_o, 0);
    sb.delete();
    tcnt = 10;
    for (int i = 0; i < 11; i++) tkey[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(K9, 1'b1, K9, tr);
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_ark_sequencer.md
INV_ARK_SEQUENCER -- requirements
Module: inv_ark_sequencer

Interface
REQ-001: clk  input  1  single clock; all state on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: rk_we  input  1  round-key write strobe.
REQ-004: rk_addr  input  4  round-key index; 0..10 valid.
REQ-005: rk_i  input  4x32 (array [3:0] of 32-bit words)  round-key columns.
REQ-006: key_err  output  1  one-cycle pulse when a key write is rejected.
REQ-007: in_valid  input  1  upstream state beat valid.
REQ-008: in_ready  output  1  block can accept a beat this cycle.
REQ-009: state_i  input  4x32 (array [3:0] of 32-bit words)  state from the inverse-round datapath.
REQ-010: out_valid  output  1  state_o valid.
REQ-011: out_ready  input  1  downstream accepts state_o.
REQ-012: state_o  output  4x32 (array [3:0] of 32-bit words)  state_i XOR selected round key, registered.
REQ-013: round_o  output  4  round index applied to the current state_o.
REQ-014: last_o  output  1  high with out_valid when round_o = 0 (final beat of a block).

Function
REQ-015: Key storage SHALL be 11 entries x 128 bits, written at the clk edge when rk_we=1, rk_addr<=10 and the block is idle.
REQ-016: Idle SHALL mean round counter = 10 and out_valid = 0.
REQ-017: A key write SHALL be rejected when rk_addr>10 or when not idle; storage is unchanged and key_err pulses high the next cycle.
REQ-018: in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019: A beat SHALL be accepted when in_valid && in_ready.
REQ-020: On acceptance, state_o[j] SHALL load state_i[j] XOR key[cnt][j] for j=0..3, round_o SHALL load cnt, out_valid SHALL be set, and latency SHALL be one cycle.
REQ-021: Round counter cnt SHALL start at 10 and decrement by one per accepted beat.
REQ-022: After the beat with cnt=0 the counter SHALL wrap to 10, so that keys are applied 10,9,...,0 per block.
REQ-023: The counter SHALL be a 2-state FSM.
  - IDLE: cnt=10, no block in progress.
  - ACTIVE: cnt<10.
  - IDLE->ACTIVE on accepting the round-10 beat.
  - ACTIVE->IDLE on accepting the round-0 beat.
REQ-024: out_valid SHALL clear when out_ready=1 and no new beat is accepted that cycle.
REQ-025: Simultaneous out_ready and in_valid while out_valid=1 SHALL replace the output with the new beat in the same edge (full throughput, one beat per cycle).
REQ-026: state_o, round_o and last_o SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027: Key writes in the same cycle as the acceptance of the round-10 beat SHALL be rejected, since the block is no longer idle after that edge; the XOR SHALL use the old key.
REQ-028: last_o SHALL be derived from the registered round_o, never from cnt.

Reset
REQ-029: Asserting rst at any time, including mid-block, SHALL asynchronously set:
  - out_valid=0, state_o=0, round_o=0, last_o=0, key_err=0
  - cnt=10, FSM=IDLE
  - all 11 key entries = 0
REQ-030: The first beat accepted after rst deasserts SHALL be treated as round 10.

Verification
REQ-031: Load key[10]={01234567,01234567,89ABCDEF,89ABCDEF}, send state_i with the same value -> one cycle later out_valid=1, state_o all zero, round_o=10, last_o=0.
REQ-032: Load key[9]={89ABCDEF,456789AB,0123CDEF,456789AB}, send state_i={01234567,01234567,89ABCDEF,89ABCDEF} as the second beat -> state_o={88888888,4444CCCC,88880000,CCCC4444}, round_o=9.
REQ-033: Stream 11 beats with out_ready=1 -> round_o sequence 10..0 on consecutive cycles, last_o=1 only on round 0, cnt back to 10 afterwards.
REQ-034: Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, state_o and round_o stable, no beat lost or duplicated.
REQ-035: Key write with rk_addr=11, then a key write after accepting the round-10 beat -> key_err pulses both times and readback through the XOR shows keys unchanged.
REQ-036: Assert rst after the round-5 output -> outputs zero immediately; the next accepted beat reports round_o=10 and is XORed with key 0 (keys cleared, so state_o = state_i).
